// File: rtl/reg_array_fifo_buf.sv
// Entry-assembling FIFO: packs NUM_WORDS RDATA words per entry, queues entries
// in a 2**AW circular buffer and presents the head entry to the OPU show-ahead.
module reg_array_fifo_buf #(
  parameter int DW        = 8,
  parameter int MAX_WORDS = 9,
  parameter int AW        = 3,
  parameter int CW        = 4
) (
  input  logic                    SYS_CLK,
  input  logic                    SYS_RST,
  input  logic                    CLR,
  input  logic [CW-1:0]           NUM_WORDS,
  input  logic [DW-1:0]           RDATA,
  input  logic                    RDATA_VLD,
  output logic                    RDATA_RDY,
  output logic [DW*MAX_WORDS-1:0] OPU_DATA,
  output logic [CW-1:0]           OPU_NUM,
  output logic                    OPU_VLD,
  input  logic                    OPU_RDY,
  output logic                    FIFO_FULL,
  output logic                    FIFO_EMPTY,
  output logic [AW:0]             FIFO_LEVEL,
  output logic                    CFG_ERR
);

  localparam int DEPTH = 2**AW;
  localparam int LW    = DW*MAX_WORDS;
  localparam logic [CW-1:0] MAXN = CW'(MAX_WORDS);

  typedef enum logic {ASM_IDLE, ASM_FILL} asm_state_t;

  asm_state_t    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, n_lat, n_lat_nx, n_eff, lane;
  logic [LW-1:0] asm_buf, asm_buf_nx, asm_vec;
  logic          cfg_err, cfg_err_nx;
  logic [AW:0]   wptr, rptr;
  logic [LW-1:0] mem_data [DEPTH];
  logic [CW-1:0] mem_num  [DEPTH];
  logic          full, empty, bad_num, last_word, accept, commit, pop;

  assign bad_num   = (NUM_WORDS == '0) || (NUM_WORDS > MAXN);
  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign RDATA_RDY = ~CLR & ~(full & last_word);
  assign accept    = RDATA_VLD & RDATA_RDY;
  assign commit    = accept & last_word;
  assign pop       = ~CLR & ~empty & OPU_RDY;

  assign OPU_DATA   = mem_data[rptr[AW-1:0]];
  assign OPU_NUM    = mem_num[rptr[AW-1:0]];
  assign OPU_VLD    = ~empty;
  assign FIFO_FULL  = full;
  assign FIFO_EMPTY = empty;
  assign FIFO_LEVEL = wptr - rptr;
  assign CFG_ERR    = cfg_err;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    n_lat_nx   = n_lat;
    cfg_err_nx = cfg_err;
    // The entry length is taken from NUM_WORDS only on the first word.
    n_eff     = (state == ASM_IDLE) ? (bad_num ? MAXN : NUM_WORDS) : n_lat;
    lane      = (state == ASM_IDLE) ? '0 : cnt;
    last_word = ((lane + CW'(1)) == n_eff);
    // Starting from zero on the first word keeps unused lanes cleared.
    asm_vec   = (state == ASM_IDLE) ? '0 : asm_buf;
    for (int unsigned k = 0; k < MAX_WORDS; k++)
      if (lane == CW'(k)) asm_vec[DW*k +: DW] = RDATA;
    asm_buf_nx = accept ? asm_vec : asm_buf;
    if (accept) begin
      n_lat_nx = n_eff;
      if (state == ASM_IDLE && bad_num) cfg_err_nx = 1'b1;
      if (last_word) begin
        state_nx = ASM_IDLE;
        cnt_nx   = '0;
      end else begin
        state_nx = ASM_FILL;
        cnt_nx   = lane + CW'(1);
      end
    end
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST)  state <= ASM_IDLE;
    else if (CLR)  state <= ASM_IDLE;
    else           state <= state_nx;
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST) begin
      cnt     <= '0;
      n_lat   <= '0;
      asm_buf <= '0;
      cfg_err <= 1'b0;
      wptr    <= '0;
      rptr    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_num[i]  <= '0;
      end
    end else if (CLR) begin
      cnt     <= '0;
      cfg_err <= 1'b0;
      wptr    <= '0;
      rptr    <= '0;
    end else begin
      cnt     <= cnt_nx;
      n_lat   <= n_lat_nx;
      asm_buf <= asm_buf_nx;
      cfg_err <= cfg_err_nx;
      if (commit) begin
        mem_data[wptr[AW-1:0]] <= asm_vec;
        mem_num[wptr[AW-1:0]]  <= n_eff;
        wptr <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: doc/reg_array_fifo_buf.md
Name: reg_array_fifo_buf

Overview:
Parametrised successor of the reg_array FIFO controller. It collects single RDATA words from the read path into entries of NUM_WORDS words (3 or 9 for conv modes, any 1..MAX_WORDS). It stores complete entries in an on-chip circular FIFO of 2**AW entries and presents them to the OPU over a valid/ready handshake. It adds data storage, input back-pressure, occupancy level, synchronous flush and config-error detection.

Parameters:
DW, 8, width of one RDATA word
MAX_WORDS, 9, maximum words per entry (OPU lanes)
AW, 3, FIFO address width; depth = 2**AW entries
CW, 4, width of NUM_WORDS / OPU_NUM; must satisfy 2**CW > MAX_WORDS

Ports:
SYS_CLK  in  1  clock, all logic on rising edge
SYS_RST  in  1  asynchronous, active-low reset
CLR  in  1  synchronous flush of FIFO and assembly state
NUM_WORDS  in  CW  words per entry, sampled on the first word of each entry
RDATA  in  DW  read data word
RDATA_VLD  in  1  RDATA valid
RDATA_RDY  out  1  block accepts RDATA this cycle
OPU_DATA  out  DW*MAX_WORDS  head entry; lane k at bits [DW*k +: DW]
OPU_NUM  out  CW  valid word count of head entry
OPU_VLD  out  1  head entry valid (FIFO not empty)
OPU_RDY  in  1  OPU consumes head entry
FIFO_FULL  out  1  2**AW entries stored
FIFO_EMPTY  out  1  no entries stored
FIFO_LEVEL  out  AW+1  entries stored, 0..2**AW
CFG_ERR  out  1  sticky: illegal NUM_WORDS seen

Behaviour:
- Reset (SYS_RST low, async): wptr, rptr, word counter, assembly buffer, latched count and CFG_ERR all clear. Outputs after reset: OPU_VLD=0, FIFO_EMPTY=1, FIFO_FULL=0, FIFO_LEVEL=0, CFG_ERR=0, RDATA_RDY=1, OPU_DATA=0, OPU_NUM=0.
- Word accept: RDATA_VLD & RDATA_RDY.
- Assembly FSM states:
  - ASM_IDLE (cnt=0): on accept, latch NUM_WORDS into n_lat, write RDATA to lane 0, cnt=1, go to ASM_FILL. If n_lat==1, commit instead and stay in ASM_IDLE.
  - ASM_FILL: on accept, write RDATA to lane cnt, cnt+1. When cnt+1==n_lat, commit and return to ASM_IDLE.
- Commit: at the same edge, write the assembled vector (including the current word, unused lanes zero) and n_lat into mem[wptr[AW-1:0]], then wptr+1. Latency from last word to OPU_VLD is 1 cycle when the FIFO was empty.
- Illegal NUM_WORDS (0 or >MAX_WORDS) at entry start: n_lat=MAX_WORDS, CFG_ERR set. CFG_ERR clears only on reset or CLR. NUM_WORDS changes mid-entry are ignored.
- Back-pressure: RDATA_RDY = ~CLR & ~(FIFO_FULL & word would commit). Partial words are still accepted while full. RDATA_RDY has no combinational dependence on OPU_RDY; a pop and a blocked commit in the same cycle do not bypass.
- Read side: show-ahead. OPU_DATA/OPU_NUM = mem[rptr] combinationally; OPU_VLD = ~FIFO_EMPTY. Pop on OPU_VLD & OPU_RDY: rptr+1. OPU_RDY while empty is ignored.
- Pointers are AW+1 bits and wrap naturally.
  - EMPTY: wptr==rptr.
  - FULL: MSBs differ and lower AW bits equal.
  - LEVEL = wptr - rptr, modulo 2**(AW+1).
- Simultaneous commit and pop (not full): both take effect and LEVEL is unchanged.
- CLR (sync, takes priority over all other events):
  - pointers, cnt and CFG_ERR go to 0 and the state goes to ASM_IDLE.
  - RDATA_RDY=0 during CLR, so words presented that cycle are dropped.
  - A pop in the CLR cycle is discarded.
  - Memory contents are not cleared.
- Reset mid-entry discards the partial entry. No X may propagate to any output after reset.

Test Plan:
- Basic 9-word entry: NUM_WORDS=9, RDATA=0x01..0x09 with VLD held, OPU_RDY=0 → OPU_VLD rises 1 cycle after word 9; OPU_DATA lanes 0..8 = 01..09; OPU_NUM=9; LEVEL=1.
- Mixed size: NUM_WORDS=3, words A1,A2,A3, then NUM_WORDS=9 entry → first pop gives lanes 0..2 = A1..A3 with lanes 3..8 = 0 and OPU_NUM=3; second pop gives 9 words; EMPTY=1 after.
- Full and back-pressure: AW=3, NUM_WORDS=1, 8 words with OPU_RDY=0 → FULL=1, LEVEL=8. The 9th word sees RDATA_RDY=0. With NUM_WORDS=3, the first 2 words of an entry are still accepted and the 3rd stalls until one pop, then commits.
- Wrap and concurrency: stream 40 entries of 3 words with OPU_RDY toggling 1/0 → entries arrive in order with no loss or duplication. A cycle with commit+pop leaves LEVEL unchanged.
- Config error: NUM_WORDS=0 at entry start → CFG_ERR=1 and the entry takes 9 words; NUM_WORDS=12 likewise. CLR → CFG_ERR=0, EMPTY=1, LEVEL=0.
- Flush/reset mid-entry: 2 of 3 words accepted, then CLR (or async SYS_RST pulse) → no entry is committed; the next 3 words form an entry starting at lane 0.
